// File: rtl/ltl_monitor_pkg.sv
// Shared definitions for the LTL monitor symbol interface.
// Holds the feeder FSM state type and the default symbol width and reset length
// that the monitor cluster is built around.
package ltl_monitor_pkg;

  localparam int unsigned LTL_SYM_W          = 8;
  localparam int unsigned LTL_RST_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    STREAM,
    DRAIN
  } feeder_state_e;

endpackage

// File: rtl/ltl_sym_fifo.sv
// Synchronous single-clock FIFO for proposition vectors.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             empties the FIFO (takes priority over push/pop)
//   push, wdata       write request and data; a push while full only lands if a pop
//                     happens in the same cycle
//   pop, rdata        read request; rdata shows the head entry (valid when !empty)
//   full, empty       occupancy flags
//   level             occupancy, 0..Depth
module ltl_sym_fifo
  import ltl_monitor_pkg::*;
#(
  parameter int unsigned Width = LTL_SYM_W,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned Aw = $clog2(Depth);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [Aw:0]      wptr_q, wptr_d;
  logic [Aw:0]      rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             wr_en;
  logic             rd_en;

  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (level == (Aw + 1)'(Depth));
  assign rdata = mem_q[rptr_q[Aw-1:0]];

  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still succeeds.
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wptr_q[Aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/ltl_symbol_feeder.sv
// Producer end of the LTL monitor symbol interface.
// Buffers per-cycle proposition vectors from the core trace tap and streams them to
// every automaton of a monitor cluster, framing each trace with a monitor reset.
// Optional feature: define LTL_FEEDER_DROP_CNT_EN to add a saturating 16-bit
// drop_cnt output; overflow is then drop_cnt != 0.
// Ports:
//   clk, rst_n        clock (shared with the monitor cluster), async active-low reset
//   trace_start       pulse: begin (or restart) a trace
//   trace_stop        pulse: end the trace once the FIFO has drained
//   prop_valid/bits   proposition vector input, no backpressure
//   symbols, run      registered symbol and consume strobe to the monitor
//   monitor_reset     active-high monitor reset, high in IDLE and RESET
//   busy              FSM not idle
//   overflow          sticky: a proposition was dropped on a full FIFO
//   drop_cnt          (optional) number of dropped propositions, saturating
//   fifo_level        FIFO occupancy
module ltl_symbol_feeder
  import ltl_monitor_pkg::*;
#(
  parameter int unsigned SYM_W      = LTL_SYM_W,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RST_CYCLES = LTL_RST_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          trace_start,
  input  logic                          trace_stop,
  input  logic                          prop_valid,
  input  logic [SYM_W-1:0]              prop_bits,
  output logic [SYM_W-1:0]              symbols,
  output logic                          run,
  output logic                          monitor_reset,
  output logic                          busy,
  output logic                          overflow,
`ifdef LTL_FEEDER_DROP_CNT_EN
  output logic [15:0]                   drop_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CntW-1:0] RstLast = CntW'(RST_CYCLES - 1);

  feeder_state_e    state_q, state_d;
  logic [CntW-1:0]  rcnt_q, rcnt_d;
  logic [SYM_W-1:0] symbols_q;
  logic             run_q;
  logic             mon_rst_q, mon_rst_d;

  logic             push_req;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [SYM_W-1:0] fifo_rdata;

  ltl_sym_fifo #(
    .Width (SYM_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (trace_start),
    .push  (push_req),
    .wdata (prop_bits),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // trace_start flushes the FIFO, so neither push nor pop may take effect with it.
  assign push_req = prop_valid && !trace_start && (state_q == RESET || state_q == STREAM);
  assign pop      = !trace_start && !fifo_empty && (state_q == STREAM || state_q == DRAIN);
  assign drop     = push_req && fifo_full && !pop;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (trace_start) begin
      state_d = RESET;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        RESET: begin
          if (rcnt_q == RstLast) state_d = STREAM;
          else                   rcnt_d  = rcnt_q + 1'b1;
        end
        STREAM: if (trace_stop) state_d = DRAIN;
        // Leave only after the last popped symbol has been presented on run.
        DRAIN:  if (fifo_empty && !run_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    mon_rst_d = (state_d == IDLE) || (state_d == RESET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      symbols_q <= '0;
      run_q     <= 1'b0;
      mon_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      run_q     <= pop;
      mon_rst_q <= mon_rst_d;
      if (pop) symbols_q <= fifo_rdata;
    end
  end

`ifdef LTL_FEEDER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (trace_start) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = (drop_cnt_q != 16'd0);
`else
  logic overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (trace_start) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

  assign symbols       = symbols_q;
  assign run           = run_q;
  assign monitor_reset = mon_rst_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ltl_symbol_feeder.sv
module tb_ltl_symbol_feeder;

  localparam int unsigned D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: RST_CYCLES=2, instance 1: RST_CYCLES=12 (lets the FIFO fill in RESET).
  logic       ts [2];
  logic       tp [2];
  logic       pv [2];
  logic [7:0] pb [2];
  logic [7:0] sym [2];
  logic       run [2];
  logic       mrst [2];
  logic       busy [2];
  logic       ovf [2];
  logic [3:0] lvl [2];
`ifdef LTL_FEEDER_DROP_CNT_EN
  logic [15:0] dcnt [2];
`endif

  ltl_symbol_feeder #(.SYM_W(8), .FIFO_DEPTH(D), .RST_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .trace_start(ts[0]), .trace_stop(tp[0]),
    .prop_valid(pv[0]), .prop_bits(pb[0]), .symbols(sym[0]), .run(run[0]),
    .monitor_reset(mrst[0]), .busy(busy[0]), .overflow(ovf[0]),
`ifdef LTL_FEEDER_DROP_CNT_EN
    .drop_cnt(dcnt[0]),
`endif
    .fifo_level(lvl[0])
  );

  ltl_symbol_feeder #(.SYM_W(8), .FIFO_DEPTH(D), .RST_CYCLES(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .trace_start(ts[1]), .trace_stop(tp[1]),
    .prop_valid(pv[1]), .prop_bits(pb[1]), .symbols(sym[1]), .run(run[1]),
    .monitor_reset(mrst[1]), .busy(busy[1]), .overflow(ovf[1]),
`ifdef LTL_FEEDER_DROP_CNT_EN
    .drop_cnt(dcnt[1]),
`endif
    .fifo_level(lvl[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int runs [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: phase 0 idle, 1 reset, 2 stream, 3 drain.
  int         mph [2];
  int         mrc [2];
  bit         movf [2];
  bit         ppop [2];
  int         mdrop [2];
  logic [7:0] mf [2][$];
  logic [39:0] expq [2][$];   // {due cycle, symbol}

  bit         s_st [2];
  bit         s_sp [2];
  bit         s_pv [2];
  logic [7:0] s_pb [2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int rst_len(input int i);
    return (i == 0) ? 2 : 12;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mph[i] = 0; mrc[i] = 0; movf[i] = 0; ppop[i] = 0; mdrop[i] = 0;
      mf[i].delete();
      expq[i].delete();
      s_st[i] = 0; s_sp[i] = 0; s_pv[i] = 0; s_pb[i] = '0;
      ts[i] = 0; tp[i] = 0; pv[i] = 0; pb[i] = '0;
    end
  endtask

  // Applies what the coming clock edge does to instance i.
  task automatic model_step(input int i);
    int  sz;
    bit  pop;
    bit  push;
    sz = mf[i].size();
    if (ts[i]) begin
      mf[i].delete();
      mph[i] = 1; mrc[i] = 0; movf[i] = 0; mdrop[i] = 0; ppop[i] = 0;
    end else begin
      pop  = (mph[i] == 2 || mph[i] == 3) && sz > 0;
      push = pv[i] && (mph[i] == 1 || mph[i] == 2);
      if (pop) expq[i].push_back({32'(cyc + 1), mf[i].pop_front()});
      if (push) begin
        if (sz == int'(D) && !pop) begin
          movf[i] = 1;
          if (mdrop[i] != 65535) mdrop[i]++;
        end else begin
          mf[i].push_back(pb[i]);
        end
      end
      case (mph[i])
        1: if (mrc[i] == rst_len(i) - 1) mph[i] = 2; else mrc[i]++;
        2: if (tp[i]) mph[i] = 3;
        3: if (sz == 0 && !ppop[i]) mph[i] = 0;
        default: ;
      endcase
      ppop[i] = pop;
    end
  endtask

  task automatic stage(input int i, input bit st, input bit sp, input bit v, input logic [7:0] b);
    s_st[i] = st; s_sp[i] = sp; s_pv[i] = v; s_pb[i] = b;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      ts[i] = s_st[i]; tp[i] = s_sp[i]; pv[i] = s_pv[i]; pb[i] = s_pb[i];
      model_step(i);
      s_st[i] = 0; s_sp[i] = 0; s_pv[i] = 0; s_pb[i] = '0;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic mon(input int i);
    logic [39:0] e;
    if (run[i]) begin
      runs[i]++;
      if (expq[i].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL run%0d: run=1 symbols=%0h, required run=0 (cycle %0d)", i, sym[i], cyc);
      end else begin
        e = expq[i].pop_front();
        check($sformatf("symbol%0d", i), 64'(sym[i]), 64'(e[7:0]));
        check($sformatf("latency%0d", i), 64'(cyc), 64'(e[39:8]));
      end
    end else if (expq[i].size() != 0 && int'(expq[i][0][39:8]) <= cyc) begin
      e = expq[i].pop_front();
      checks++;
      errors++;
      $display("FAIL run%0d: run=0, required run=1 with symbol %0h (cycle %0d)", i, e[7:0], cyc);
    end
    check($sformatf("monitor_reset%0d", i), 64'(mrst[i]), 64'(mph[i] <= 1));
    check($sformatf("busy%0d", i), 64'(busy[i]), 64'(mph[i] != 0));
    check($sformatf("overflow%0d", i), 64'(ovf[i]), 64'(movf[i]));
    check($sformatf("level%0d", i), 64'(lvl[i]), 64'(mf[i].size()));
`ifdef LTL_FEEDER_DROP_CNT_EN
    check($sformatf("drop_cnt%0d", i), 64'(dcnt[i]), 64'(mdrop[i]));
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_symbols%0d", tag, i), 64'(sym[i]), 64'h0);
      check($sformatf("%s_run%0d", tag, i), 64'(run[i]), 64'h0);
      check($sformatf("%s_monrst%0d", tag, i), 64'(mrst[i]), 64'h1);
      check($sformatf("%s_busy%0d", tag, i), 64'(busy[i]), 64'h0);
      check($sformatf("%s_ovf%0d", tag, i), 64'(ovf[i]), 64'h0);
      check($sformatf("%s_level%0d", tag, i), 64'(lvl[i]), 64'h0);
    end
  endtask

  initial begin
    int r0;
    runs[0] = 0;
    runs[1] = 0;
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Basic trace on instance 0.
    r0 = runs[0];
    stage(0, 1, 0, 0, 8'h00); tick();
    ticks(2);
    stage(0, 0, 0, 1, 8'h05); tick();
    stage(0, 0, 0, 1, 8'h42); tick();
    stage(0, 0, 0, 1, 8'hC0); tick();
    ticks(6);
    check("basic_runs", 64'(runs[0] - r0), 64'd3);

    // Overflow: 10 pushes during a 12-cycle RESET on instance 1.
    stage(1, 1, 0, 0, 8'h00); tick();
    for (int k = 0; k < 10; k++) begin
      stage(1, 0, 0, 1, 8'(8'h10 + k)); tick();
    end
    @(posedge clk);
    #1;
    check("ovf_level", 64'(lvl[1]), 64'd8);
    check("ovf_flag", 64'(ovf[1]), 64'd1);
`ifdef LTL_FEEDER_DROP_CNT_EN
    check("ovf_drop_cnt", 64'(dcnt[1]), 64'd2);
`endif
    ticks(20);
    stage(1, 0, 1, 0, 8'h00); tick();
    ticks(5);

    // Full FIFO with simultaneous push and pop in STREAM.
    stage(1, 1, 0, 0, 8'h00); tick();
    ticks(4);
    for (int k = 0; k < 14; k++) begin
      stage(1, 0, 0, 1, 8'($urandom)); tick();
    end
    @(posedge clk);
    #1;
    check("full_level", 64'(lvl[1]), 64'd8);
    check("full_ovf", 64'(ovf[1]), 64'd0);

    // Drain with 5 entries queued; pushes during DRAIN are ignored.
    stage(1, 1, 0, 0, 8'h00); tick();
    ticks(7);
    for (int k = 0; k < 5; k++) begin
      stage(1, 0, 0, 1, 8'(8'hA0 + k)); tick();
    end
    r0 = runs[1];
    stage(1, 0, 1, 0, 8'h00); tick();
    for (int k = 0; k < 12; k++) begin
      stage(1, 0, 0, 1, 8'($urandom)); tick();
    end
    @(posedge clk);
    #1;
    check("drain_runs", 64'(runs[1] - r0), 64'd5);
    check("drain_busy", 64'(busy[1]), 64'd0);
    check("drain_monrst", 64'(mrst[1]), 64'd1);

    // Restart mid-STREAM with 4 entries queued and overflow set.
    stage(1, 1, 0, 0, 8'h00); tick();
    for (int k = 0; k < 12; k++) begin
      stage(1, 0, 0, 1, 8'($urandom)); tick();
    end
    ticks(4);
    stage(1, 1, 0, 0, 8'h00); tick();
    @(posedge clk);
    #1;
    check("restart_level", 64'(lvl[1]), 64'd0);
    check("restart_ovf", 64'(ovf[1]), 64'd0);
    check("restart_monrst", 64'(mrst[1]), 64'd1);
    r0 = runs[1];
    ticks(11);
    check("restart_runs", 64'(runs[1] - r0), 64'd0);
    ticks(20);

    // Asynchronous reset mid-STREAM on instance 0.
    stage(0, 1, 0, 0, 8'h00); tick();
    for (int k = 0; k < 4; k++) begin
      stage(0, 0, 0, 1, 8'($urandom)); tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(negedge clk);
    check("async_norun", 64'(run[0]), 64'd0);
    #1 rst_n = 1'b1;

    // Randomised traffic on both instances.
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < 2; i++) begin
        stage(i, $urandom_range(0, 149) == 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 9) < 7, 8'($urandom));
      end
      tick();
    end
    stage(0, 0, 1, 0, 8'h00);
    stage(1, 0, 1, 0, 8'h00);
    tick();
    ticks(60);
    check("end_queue0", 64'(expq[0].size()), 64'd0);
    check("end_queue1", 64'(expq[1].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
